// File: rtl/mem_pkg.sv
// Shared definitions for the sized byte memory: size encodings, FSM states
// and small helpers for access width and alignment.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // The illegal size reports 4 bytes; it is flagged as an error separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addrLow, input logic [1:0] size);
    case (size)
      SZ_HALF: is_misaligned = addrLow[0];
      SZ_WORD: is_misaligned = (addrLow != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte or half from a little-endian word and
// sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] wordIn,
  input  logic [1:0]  addrLow,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  output logic [31:0] result
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = wordIn[{addrLow, 3'b000} +: 8];
    halfLane = addrLow[1] ? wordIn[31:16] : wordIn[15:0];
    result   = wordIn;
    case (size)
      SZ_BYTE: result = {{24{signedLoad & byteLane[7]}}, byteLane};
      SZ_HALF: result = {{16{signedLoad & halfLane[15]}}, halfLane};
      default: result = wordIn;
    endcase
  end

endmodule

// File: rtl/sized_byte_mem.sv
// Byte-addressable data memory with sized accesses, a single-outstanding
// valid/ready handshake, configurable read latency and optional zero-fill.
module sized_byte_mem
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_BYTES    = 4096,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int WORD_AW     = $clog2(DEPTH_WORDS);
  localparam int IDX_W       = (WORD_AW < 1) ? 1 : WORD_AW;
  localparam int CNT_W       = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  state_t state, nextState;

  logic [31:0]      memArray [DEPTH_WORDS];
  logic [IDX_W-1:0] initPtr;
  logic [IDX_W-1:0] wordIdx;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      rdataReg;
  logic             errReg;
  logic             readyReg;
  logic             acceptReq;
  logic             reqErr;
  logic [ADDR_W:0]  lastAddr;
  logic [31:0]      readWord;
  logic [31:0]      loadResult;
  logic [3:0]       byteEn;
  logic [31:0]      storeWord;

  assign wordIdx   = IDX_W'(req_addr >> 2);
  assign readWord  = memArray[wordIdx];
  assign acceptReq = req_valid && readyReg;

  // Range check is done one bit wider than the address so it cannot wrap.
  assign lastAddr = {1'b0, req_addr} + (ADDR_W + 1)'(size_bytes(req_size)) - (ADDR_W + 1)'(1);
  assign reqErr   = (req_size == SZ_ILLEGAL) || is_misaligned(req_addr[1:0], req_size) ||
                    (lastAddr >= (ADDR_W + 1)'(DEPTH_BYTES));

  load_extend u_load_extend (
    .wordIn     (readWord),
    .addrLow    (req_addr[1:0]),
    .size       (req_size),
    .signedLoad (req_signed),
    .result     (loadResult)
  );

  always_comb begin
    byteEn    = 4'b0000;
    storeWord = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        byteEn    = 4'b0001 << req_addr[1:0];
        storeWord = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        byteEn    = 4'b0011 << req_addr[1:0];
        storeWord = {2{req_wdata[15:0]}};
      end
      SZ_WORD: byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // req_ready is registered from the next state so it stays low while reset
  // is held, which also keeps stores out of the array during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      readyReg <= 1'b0;
    end else begin
      state    <= nextState;
      readyReg <= (nextState == ST_IDLE);
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_INIT: if (initPtr == IDX_W'(DEPTH_WORDS - 1)) nextState = ST_IDLE;
      ST_IDLE: if (acceptReq) nextState = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (waitCnt == CNT_W'(1)) nextState = ST_RESP;
      ST_RESP: if (resp_ready) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      initPtr  <= '0;
      waitCnt  <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      if (state == ST_INIT) initPtr <= initPtr + IDX_W'(1);
      if (acceptReq) begin
        waitCnt  <= CNT_W'(LATENCY - 1);
        rdataReg <= (req_we || reqErr) ? 32'h0 : loadResult;
        errReg   <= reqErr;
      end else if (state == ST_WAIT) begin
        waitCnt <= waitCnt - CNT_W'(1);
      end
      if (state == ST_RESP && resp_ready) begin
        rdataReg <= '0;
        errReg   <= 1'b0;
      end
    end
  end

  // The array itself is never reset; only the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      memArray[initPtr] <= '0;
    end else if (acceptReq && req_we && !reqErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) memArray[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
      end
    end
  end

  assign req_ready  = readyReg;
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdataReg;
  assign resp_err   = errReg;
  assign busy       = (state == ST_INIT);

endmodule

// File: tb/tb_sized_byte_mem.sv
// Scoreboard bench for sized_byte_mem: a byte-array model predicts each
// response, which is queued at request time and compared when it returns.
module tb_sized_byte_mem;
  import mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4096;
  localparam int LAT    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] refMem [DEPTH];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  sized_byte_mem #(
    .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic modelErr(input logic [31:0] addr, input logic [1:0] size);
    logic [32:0] last;
    last = {1'b0, addr} + 33'(nBytes(size)) - 33'd1;
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (last >= 33'(DEPTH));
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    int nb;
    nb = nBytes(size);
    v  = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = refMem[int'(addr) + i];
    if (sgn && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (sgn && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < nBytes(size); i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                               input int holdCycles);
    exp_t e, got;
    int w, k;
    e.err   = modelErr(addr, size);
    e.rdata = (we || e.err) ? 32'h0 : modelLoad(addr, size, sgn);
    if (we && !e.err) modelStore(addr, size, wdata);
    expQ.push_back(e);

    w = 0;
    while (!req_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checkOutput({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
      void'(expQ.pop_front());
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    resp_ready = (holdCycles == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_latency"}, 32'(k), 32'(LAT));
    got = expQ.pop_front();
    if (!resp_valid) begin
      resp_ready = 1'b1;
      return;
    end
    checkOutput({tag, "_rdata"}, resp_rdata, got.rdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(got.err));
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, got.rdata);
      checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'h1);
      checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_post_valid"}, 32'(resp_valid), 32'h0);
    checkOutput({tag, "_post_ready"}, 32'(req_ready), 32'h1);
    checkOutput({tag, "_post_rdata"}, resp_rdata, 32'h0);
  endtask

  task automatic waitInit(input string tag);
    int cnt, bad;
    cnt = 0;
    bad = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    while (busy && cnt < 2000) begin
      cnt++;
      if (req_ready) bad++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, 32'(cnt), 32'd1024);
    checkOutput({tag, "_ready_during_init"}, 32'(bad), 32'h0);
    clearModel();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_err", 32'(resp_err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);

    waitInit("init1");
    applyStimulus("top_word_zero", 1'b0, 32'hFFC, SZ_WORD, 1'b0, 32'h0, 0);

    applyStimulus("st_word", 1'b1, 32'h100, SZ_WORD, 1'b0, 32'hDEADBEEF, 0);
    applyStimulus("ld_byte_s", 1'b0, 32'h100, SZ_BYTE, 1'b1, 32'h0, 0);
    applyStimulus("ld_byte_u", 1'b0, 32'h101, SZ_BYTE, 1'b0, 32'h0, 0);
    applyStimulus("ld_half_s", 1'b0, 32'h102, SZ_HALF, 1'b1, 32'h0, 0);
    applyStimulus("ld_word", 1'b0, 32'h100, SZ_WORD, 1'b0, 32'h0, 4);

    applyStimulus("st_half_misal", 1'b1, 32'h101, SZ_HALF, 1'b0, 32'h0000AAAA, 0);
    applyStimulus("ld_word_misal", 1'b0, 32'h102, SZ_WORD, 1'b0, 32'h0, 0);
    applyStimulus("illegal_size", 1'b0, 32'h0, SZ_ILLEGAL, 1'b0, 32'h0, 0);
    applyStimulus("ld_word_intact", 1'b0, 32'h100, SZ_WORD, 1'b0, 32'h0, 0);

    applyStimulus("st_word_top", 1'b1, 32'hFFC, SZ_WORD, 1'b0, 32'hCAFEF00D, 0);
    applyStimulus("ld_half_fff", 1'b0, 32'hFFF, SZ_HALF, 1'b0, 32'h0, 0);
    applyStimulus("ld_word_1000", 1'b0, 32'h1000, SZ_WORD, 1'b0, 32'h0, 0);
    applyStimulus("ld_byte_fff", 1'b0, 32'hFFF, SZ_BYTE, 1'b1, 32'h0, 0);
    applyStimulus("ld_word_top", 1'b0, 32'hFFC, SZ_WORD, 1'b0, 32'h0, 0);

    for (int r = 0; r < 24; r++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(4088, 4100)) : 32'($urandom_range(0, 63));
      applyStimulus("rand", 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, 0);
    end

    // Reset arrives in the second WAIT cycle of a load; the response must vanish.
    applyStimulus("st_pre_reset", 1'b1, 32'h40, SZ_WORD, 1'b0, 32'h12345678, 0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h40;
    req_size  = SZ_WORD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("wait_state_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("mid_rst_rdata", resp_rdata, 32'h0);
    checkOutput("mid_rst_err", 32'(resp_err), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h1);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      checkOutput("mid_rst_no_resp", 32'(seen), 32'h0);
    end
    waitInit("init2");
    applyStimulus("ld_after_clear", 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0, 0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sized_byte_mem.md
Name: sized_byte_mem

Overview:
Parametrised successor to the processor's byte-addressable data memory. Adds byte/half/word sized accesses with sign- or zero-extension, a valid/ready request-response handshake with configurable read latency, misalignment and range error reporting, and an optional hardware zero-fill after reset. Sits between the MEM pipeline stage and the storage array. One transaction is outstanding at a time.

Parameters:
ADDR_W, 32, request address width in bits
DEPTH_BYTES, 4096, array size in bytes; must be a power of two and at least 4
LATENCY, 1, cycles from request accept to resp_valid; must be at least 1
CLEAR_ON_RESET, 1, when 1, zero-fills the whole array after reset deasserts

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
req_wdata  in  32  store data; low bytes used for byte/half stores
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load data (extended); 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal size
busy  out  1  zero-fill in progress

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=CLEAR_ON_RESET. FSM goes to INIT if CLEAR_ON_RESET=1, otherwise to IDLE.
- Array contents are not cleared by the reset pulse itself. Only INIT writes them.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT: clears one 32-bit word per cycle, with word pointer 0 to DEPTH_BYTES/4-1. busy=1 and req_ready=0. After the last word: busy=0, go to IDLE. Takes exactly DEPTH_BYTES/4 cycles.
- IDLE: req_ready=1. Accept occurs on req_valid && req_ready at posedge.
- Error check at accept:
  - req_size=11 is an error.
  - A half access with addr[0]=1 is an error.
  - A word access with addr[1:0]!=0 is an error.
  - An access is an error if addr+bytes-1 >= DEPTH_BYTES; compare in ADDR_W+1 bits, no wrap.
  - On error: no array write; the response carries resp_err=1 and rdata=0.
- Store: committed to the array at the accept edge, little-endian (wdata[7:0] goes to addr). Response carries rdata=0 and err=0.
- Load: array bytes are sampled at the accept edge. The addressed byte or half goes to the low bits and is extended per req_signed. The value is held in a result register until the response completes.
- Latency:
  - LATENCY=1: next state after accept is RESP.
  - Otherwise: WAIT loads counter LATENCY-1, decrements each cycle, and moves to RESP when the counter reaches 1.
  - resp_valid first rises exactly LATENCY cycles after the accept edge.
- RESP: resp_valid=1, with rdata and err stable until resp_valid && resp_ready. Then return to IDLE, with resp_valid=0 and rdata/err cleared. req_ready is not asserted in the same cycle. Minimum spacing between accepts is LATENCY+1 cycles.
- req_ready stays 0 in WAIT and RESP; requests arriving then are simply not accepted.
- Reset mid-operation: any pending response is dropped and outputs return to reset values. A store already committed stays written unless INIT subsequently clears it.
- Loads never see partially written data, because there is a single outstanding transaction.

Decomposition:
- Shared package mem_pkg holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL;
  - FSM state enum;
  - function size_bytes(size) returning 1/2/4;
  - function is_misaligned(addr, size).
- One sub-module, load_extend: combinational byte/half lane select and sign/zero extension. Inputs are the word, addr[1:0], size and signed flag; output is the 32-bit result.

Test Plan:
1. CLEAR_ON_RESET=1, DEPTH_BYTES=4096: release reset -> busy=1 for exactly 1024 cycles, req_ready=0 throughout; then word load at 0xFFC returns 0x00000000.
2. Word store 0xDEADBEEF at 0x100, then loads at 0x100 -> byte signed at 0x100 = 0xFFFFFFEF; byte unsigned at 0x101 = 0x000000BE; half signed at 0x102 = 0xFFFFDEAD; word = 0xDEADBEEF.
3. LATENCY=3, load accepted at cycle N -> resp_valid rises at N+3; holding resp_ready=0 for 4 cycles keeps rdata stable and req_ready=0; req_ready returns the cycle after the handshake.
4. Half store at 0x101, word load at 0x102, size=11 at 0x0 -> each response has resp_err=1 and rdata=0; a word load at 0x100 afterwards still returns its prior contents.
5. Word access at 0xFFC is OK; half at 0xFFF errors; word at 0x1000 errors; byte at 0xFFF is OK.
6. Assert reset two cycles into WAIT of a load -> resp_valid never rises and all outputs are at reset values; a store made before the reset reads 0 after the INIT zero-fill.
